// File: rtl/rv_pkg.sv
// Shared RV32I architectural constants used by the register file,
// decoder and hazard logic.
package rv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NREGS    = 32;
    localparam int unsigned AW       = $clog2(NREGS);
    localparam int unsigned REG_ZERO = 0;

endpackage : rv_pkg

// File: rtl/register_file.sv
// RV32I integer register file: two combinational read ports and one
// synchronous write port; x0 is hardwired to zero at the read mux.
module register_file #(
    parameter int unsigned XLEN  = rv_pkg::XLEN,
    parameter int unsigned NREGS = rv_pkg::NREGS,
    parameter int unsigned AW    = rv_pkg::AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            WE3,
    input  logic [AW-1:0]   RA1,
    input  logic [AW-1:0]   RA2,
    input  logic [AW-1:0]   WA3,
    input  logic [XLEN-1:0] WD3,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2
);
    import rv_pkg::*;

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    generate
        if (AW != $clog2(NREGS)) begin : g_bad_aw
            $error("register_file: AW must equal clog2(NREGS)");
        end
    endgenerate

    // Entry 0 of the read view is a constant, so no storage exists for x0.
    logic [NREGS-1:0][XLEN-1:0] rf_view;
    logic [NREGS-1:0]           wr_sel;

    assign rf_view[0] = '0;
    assign wr_sel[0]  = 1'b0;

    generate
        for (genvar i = 1; i < NREGS; i++) begin : g_reg
            logic [XLEN-1:0] reg_q;
            logic [XLEN-1:0] reg_d;

            assign wr_sel[i] = WE3 && (WA3 == AW'(i));

            always_comb begin
                reg_d = reg_q;
                if (wr_sel[i]) begin
                    reg_d = WD3;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign rf_view[i] = reg_q;
        end
    endgenerate

    always_comb begin
        RD1 = rf_view[RA1];
        RD2 = rf_view[RA2];
        if (RA1 == ZERO_ADDR) begin
            RD1 = '0;
        end
        if (RA2 == ZERO_ADDR) begin
            RD2 = '0;
        end
    end

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus a
// randomized run against an array-based reference model.
`timescale 1ns/10ps
module tb_register_file;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            WE3 = 1'b0;
    logic [AW-1:0]   RA1 = '0;
    logic [AW-1:0]   RA2 = '0;
    logic [AW-1:0]   WA3 = '0;
    logic [XLEN-1:0] WD3 = '0;
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;

    int errors = 0;
    int checks = 0;

    // Architectural state as the ISA sees it; entry 0 is never written.
    logic [XLEN-1:0] model [NREGS];

    register_file #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .WE3(WE3),
        .RA1(RA1), .RA2(RA2), .WA3(WA3), .WD3(WD3),
        .RD1(RD1), .RD2(RD2)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    // One clocked write; the model commits at the edge under the ISA rules.
    task automatic do_write(input logic we, input int wa, input logic [XLEN-1:0] wd);
        @(negedge clk);
        WE3 = we; WA3 = AW'(wa); WD3 = wd;
        @(posedge clk);
        if (we && !rst && wa != 0) model[wa] = wd;
        #1;
        WE3 = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREGS; i++) begin
            RA1 = AW'(i); RA2 = AW'(NREGS - 1 - i);
            #1;
            checks++;
            if (RD1 !== '0 || RD2 !== '0) begin
                errors++;
                $display("FAIL reset_hold a=%0d RD1=%h RD2=%h want 0", i, RD1, RD2);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < NREGS; i++) begin
            RA1 = AW'(i); RA2 = AW'(i);
            #0.1;
            checks++;
            if (RD1 !== '0 || RD2 !== '0) begin
                errors++;
                $display("FAIL reset_release a=%0d RD1=%h RD2=%h want 0", i, RD1, RD2);
            end
        end
    endtask

    task automatic test_basic();
        do_write(1'b1, 1, 32'd12345678);
        RA1 = 5'd1; RA2 = 5'd1; #1;
        checks++;
        if (RD1 !== 32'd12345678 || RD2 !== 32'd12345678) begin
            errors++;
            $display("FAIL basic_r1 RD1=%h RD2=%h want %h", RD1, RD2, 32'd12345678);
        end
        do_write(1'b1, 2, 32'd87654321);
        RA1 = 5'd2; RA2 = 5'd2; #1;
        checks++;
        if (RD1 !== 32'd87654321 || RD2 !== 32'd87654321) begin
            errors++;
            $display("FAIL basic_r2 RD1=%h RD2=%h want %h", RD1, RD2, 32'd87654321);
        end
        RA1 = 5'd1; RA2 = 5'd2; #1;
        checks++;
        if (RD1 !== 32'd12345678 || RD2 !== 32'd87654321) begin
            errors++;
            $display("FAIL basic_indep RD1=%h RD2=%h want %h %h", RD1, RD2, 32'd12345678, 32'd87654321);
        end
    endtask

    task automatic test_x0();
        do_write(1'b1, 0, 32'hDEADBEEF);
        RA1 = 5'd0; RA2 = 5'd0; #1;
        checks++;
        if (RD1 !== '0 || RD2 !== '0) begin
            errors++;
            $display("FAIL x0_write RD1=%h RD2=%h want 0", RD1, RD2);
        end
    endtask

    task automatic test_write_disable();
        do_write(1'b0, 3, 32'hFFFFFFFF);
        do_write(1'b0, 1, 32'hFFFFFFFF);
        RA1 = 5'd3; RA2 = 5'd1; #1;
        checks++;
        if (RD1 !== model[3] || RD2 !== model[1]) begin
            errors++;
            $display("FAIL we_off RD1=%h RD2=%h want %h %h", RD1, RD2, model[3], model[1]);
        end
    endtask

    task automatic test_rdw();
        do_write(1'b1, 5, 32'd7);
        @(negedge clk);
        WE3 = 1'b1; WA3 = 5'd5; WD3 = 32'hA5A5A5A5; RA1 = 5'd5; RA2 = 5'd5;
        #1;
        checks++;
        if (RD1 !== 32'd7 || RD2 !== 32'd7) begin
            errors++;
            $display("FAIL rdw_before RD1=%h RD2=%h want %h", RD1, RD2, 32'd7);
        end
        @(posedge clk);
        model[5] = 32'hA5A5A5A5;
        #1;
        WE3 = 1'b0;
        checks++;
        if (RD1 !== 32'hA5A5A5A5 || RD2 !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL rdw_after RD1=%h RD2=%h want %h", RD1, RD2, 32'hA5A5A5A5);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 1; i < NREGS; i++) do_write(1'b1, i, XLEN'(i) * 32'h01010101);
        for (int i = 0; i < NREGS; i++) begin
            RA1 = AW'(i); RA2 = AW'(i); #0.1;
            checks++;
            if (RD1 !== model[i] || RD2 !== model[i]) begin
                errors++;
                $display("FAIL fill a=%0d RD1=%h RD2=%h want %h", i, RD1, RD2, model[i]);
            end
        end
        // Pulse reset between edges with a write pending; it must be lost.
        @(negedge clk);
        WE3 = 1'b1; WA3 = 5'd9; WD3 = 32'h12344321;
        #1;
        rst = 1'b1;
        model_clear();
        for (int i = 0; i < NREGS; i++) begin
            RA1 = AW'(i); RA2 = AW'(NREGS - 1 - i); #0.1;
            checks++;
            if (RD1 !== '0 || RD2 !== '0) begin
                errors++;
                $display("FAIL async_rst a=%0d RD1=%h RD2=%h want 0", i, RD1, RD2);
            end
        end
        @(posedge clk);
        #1;
        RA1 = 5'd9; RA2 = 5'd9; #0.1;
        checks++;
        if (RD1 !== '0 || RD2 !== '0) begin
            errors++;
            $display("FAIL rst_write_ignored RD1=%h RD2=%h want 0", RD1, RD2);
        end
        @(negedge clk);
        WE3 = 1'b0;
        rst = 1'b0;
        do_write(1'b1, 9, 32'h0BADF00D);
        RA1 = 5'd9; RA2 = 5'd31; #1;
        checks++;
        if (RD1 !== 32'h0BADF00D || RD2 !== '0) begin
            errors++;
            $display("FAIL first_after_rst RD1=%h RD2=%h want %h 0", RD1, RD2, 32'h0BADF00D);
        end
    endtask

    task automatic test_random();
        logic            we;
        int              wa;
        logic [XLEN-1:0] wd;
        for (int n = 0; n < 400; n++) begin
            we = ($urandom_range(0, 3) != 0);
            wa = $urandom_range(0, NREGS - 1);
            wd = $urandom;
            @(negedge clk);
            WE3 = we; WA3 = AW'(wa); WD3 = wd;
            RA1 = AW'($urandom_range(0, NREGS - 1));
            RA2 = (n % 5 == 0) ? AW'(wa) : AW'($urandom_range(0, NREGS - 1));
            #1;
            checks++;
            if (RD1 !== model[RA1] || RD2 !== model[RA2]) begin
                errors++;
                $display("FAIL rand_pre n=%0d ra=%0d/%0d RD1=%h RD2=%h want %h %h",
                         n, RA1, RA2, RD1, RD2, model[RA1], model[RA2]);
            end
            @(posedge clk);
            if (we && wa != 0) model[wa] = wd;
            #1;
            checks++;
            if (RD1 !== model[RA1] || RD2 !== model[RA2]) begin
                errors++;
                $display("FAIL rand_post n=%0d ra=%0d/%0d RD1=%h RD2=%h want %h %h",
                         n, RA1, RA2, RD1, RD2, model[RA1], model[RA2]);
            end
        end
        WE3 = 1'b0;
    endtask

    initial begin
        model_clear();
        #2;
        test_reset();
        test_basic();
        test_x0();
        test_write_disable();
        test_rdw();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_register_file
